// File: rtl/wb_dmem_line_responder.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// wb_dmem_line_responder
//
// Line-granular backing memory for a data cache. Each request moves one whole
// cache line: a fill (read) or a writeback (write). Every request is served
// after a fixed wait of LATENCY cycles and then completed with a one-cycle
// acknowledge. Addresses beyond the backing store are flagged with mem_err_o
// and never alias onto a real line.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset (RAM contents are not reset)
//   mem_req_i    request valid, held by the requester until mem_ack_o
//   mem_wr_i     1 = line writeback, 0 = line fill
//   mem_addr_i   request byte address (offset bits ignored)
//   mem_wdata_i  writeback line data
//   mem_rdata_o  fill line data, registered, held until the next fill ack
//   mem_ack_o    one-cycle completion pulse
//   mem_err_o    out-of-range flag, only meaningful with mem_ack_o
//   mem_busy_o   high whenever a transaction is in flight (WAIT or ACK)
// ----------------------------------------------------------------------------
module wb_dmem_line_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int OFFSET_BITS = 4,
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_req_i,
    input  logic                  mem_wr_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [LINE_WIDTH-1:0] mem_wdata_i,
    output logic [LINE_WIDTH-1:0] mem_rdata_o,
    output logic                  mem_ack_o,
    output logic                  mem_err_o,
    output logic                  mem_busy_o
);

    localparam int         IDX_BITS = $clog2(DEPTH_LINES);
    localparam int         TAG_LSB  = OFFSET_BITS + IDX_BITS;
    localparam logic [3:0] LAT_M1   = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t                state_reg;
    logic [3:0]            cnt_reg;
    logic                  wr_reg;
    logic                  oor_reg;
    logic [IDX_BITS-1:0]   idx_reg;
    logic [LINE_WIDTH-1:0] wdata_reg;
    logic [LINE_WIDTH-1:0] rdata_reg;
    logic                  ack_reg;
    logic                  err_reg;
    logic                  busy_reg;

    // Backing store: single port, one line per word, never reset.
    logic [LINE_WIDTH-1:0] ram [DEPTH_LINES];

    logic req_oor;
    logic wait_done;
    logic ram_we;

    // The byte offset within a line carries no information for this block.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr_i[OFFSET_BITS-1:0];

    // Any set bit above the line index means the line number is at least
    // DEPTH_LINES, so the request must be rejected rather than wrapped.
    generate
        if (ADDR_WIDTH > TAG_LSB) begin : g_oor
            assign req_oor = |mem_addr_i[ADDR_WIDTH-1:TAG_LSB];
        end else begin : g_no_oor
            assign req_oor = 1'b0;
        end
    endgenerate

    assign wait_done = (state_reg == ST_WAIT) && (cnt_reg == 4'd0);
    assign ram_we    = wait_done && wr_reg && !oor_reg;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[idx_reg] <= wdata_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            wr_reg    <= 1'b0;
            oor_reg   <= 1'b0;
            idx_reg   <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (mem_req_i) begin
                        wr_reg    <= mem_wr_i;
                        oor_reg   <= req_oor;
                        idx_reg   <= mem_addr_i[TAG_LSB-1:OFFSET_BITS];
                        wdata_reg <= mem_wdata_i;
                        cnt_reg   <= LAT_M1;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= ST_ACK;
                        ack_reg   <= 1'b1;
                        err_reg   <= oor_reg;
                        // Writes leave the fill register alone; rejected
                        // requests of either kind clear it.
                        if (oor_reg) begin
                            rdata_reg <= '0;
                        end else if (!wr_reg) begin
                            rdata_reg <= ram[idx_reg];
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_ACK: begin
                    state_reg <= ST_IDLE;
                    ack_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ack_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rdata_o = rdata_reg;
    assign mem_ack_o   = ack_reg;
    assign mem_err_o   = err_reg;
    assign mem_busy_o  = busy_reg;

endmodule

// File: doc/wb_dmem_line_responder.md
WB_DMEM_LINE_RESPONDER -- requirements
Module: wb_dmem_line_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter LINE_WIDTH, default 128, cache-line width in bits.
REQ-003 SHALL have parameter OFFSET_BITS, default 4, line-offset bits ignored in the address.
REQ-004 SHALL have parameter DEPTH_LINES, default 256, number of backing lines (power of two).
REQ-005 SHALL have parameter LATENCY, default 4, wait cycles per access (legal range 1..15).
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset (one clock; reset is asynchronous and active-low).
REQ-008 SHALL have port mem_req_i, input, 1, request valid, held high by the requester until mem_ack_o.
REQ-009 SHALL have port mem_wr_i, input, 1, 1 = line writeback, 0 = line fill.
REQ-010 SHALL have port mem_addr_i, input, ADDR_WIDTH, request byte address.
REQ-011 SHALL have port mem_wdata_i, input, LINE_WIDTH, writeback line data.
REQ-012 SHALL have port mem_rdata_o, output, LINE_WIDTH, fill line data, registered.
REQ-013 SHALL have port mem_ack_o, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port mem_err_o, output, 1, out-of-range flag, valid only with mem_ack_o.
REQ-015 SHALL have port mem_busy_o, output, 1, high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and ACK.
REQ-017 In IDLE with mem_req_i=1 at a rising edge, SHALL accept the request: latch mem_wr_i, mem_addr_i and mem_wdata_i, load the 4-bit counter with LATENCY-1, and enter WAIT.
REQ-018 In WAIT, SHALL decrement the counter each cycle and enter ACK on the edge where counter==0, so WAIT lasts exactly LATENCY cycles.
REQ-019 SHALL drive mem_ack_o=1 only in ACK, which lasts exactly one cycle before returning to IDLE.
REQ-020 SHALL ignore mem_req_i, mem_wr_i, mem_addr_i and mem_wdata_i in WAIT and ACK; changes to them mid-transaction have no effect.
REQ-021 Line index SHALL be latched addr[OFFSET_BITS+log2(DEPTH_LINES)-1:OFFSET_BITS]; addr[OFFSET_BITS-1:0] SHALL be ignored.
REQ-022 A request SHALL be out of range when latched addr[ADDR_WIDTH-1:OFFSET_BITS] >= DEPTH_LINES; no wrap-around aliasing is permitted.
REQ-023 For an in-range write, SHALL write the latched data to RAM[index] on the edge entering ACK and SHALL leave mem_rdata_o unchanged.
REQ-024 For an in-range read, SHALL load mem_rdata_o with RAM[index] on the edge entering ACK; a write to the same line immediately before SHALL be visible.
REQ-025 For an out-of-range request, SHALL assert mem_err_o=1 for the ACK cycle, perform no RAM write, and load mem_rdata_o with 0.
REQ-026 mem_err_o SHALL be 0 whenever mem_ack_o is 0.
REQ-027 mem_rdata_o SHALL hold its value until the next read ACK.
REQ-028 A requester that holds mem_req_i high through ACK SHALL have it sampled in the following IDLE cycle as a new request; mem_busy_o SHALL be low for exactly that one cycle.
REQ-029 RAM SHALL be inferable single-port, one line wide, with no byte enables.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE, counter 0, mem_ack_o=0, mem_err_o=0, mem_busy_o=0 and mem_rdata_o=0.
REQ-031 Reset during WAIT or ACK SHALL abort the transaction with no RAM write and no ack.
REQ-032 RAM contents SHALL NOT be reset; they SHALL be retained across reset and undefined after power-up.

Verification
REQ-033 Write 0x0000_0120 with data 0x11112222_33334444_55556666_77778888, then read 0x0000_012C -> each ack arrives 5 cycles after the accept edge, and the read returns the written data with mem_err_o=0.
REQ-034 Read 0x0000_1000 (line 256) -> ack with mem_err_o=1 and mem_rdata_o=0; a subsequent read of line 0 returns its earlier contents.
REQ-035 Write line 3 = A, then assert rst_n=0 during WAIT of a write of B to line 3 -> outputs are 0 immediately; a read of line 3 after reset returns A.
REQ-036 mem_req_i held high across two requests -> the second request is accepted the cycle after ACK, with mem_busy_o low for exactly 1 cycle.
REQ-037 LATENCY=1: request accepted -> mem_ack_o is high in the second cycle after the accept edge, and busy spans 2 cycles.
REQ-038 Change mem_addr_i and mem_wdata_i during WAIT -> the originally latched line and data are written.
